alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Parametrised, registered ALU/flags execution unit for the SAP CPU datapath.
- Successor to the fixed 8-bit combinational ALU plus flag latch: generic width, 16 ops, an overflow flag, and an iterative multi-cycle multiply.
- Uses a start/done handshake, so the control unit can stall its microstep counter on busy_o.
- Sits between the A/B/C/temp register outputs and the internal bus. Owns the Z/N/C/V flag register.

Parameters:
- DATA_WIDTH, 8: operand, result and flag-evaluation width; legal range 4..32.
- ENABLE_MUL, 1: 1 builds the iterative multiplier; 0 makes OP_MUL behave as OP_PASS_B.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start_i  in  1  launch op_i on a_i/b_i; sampled only when busy_o=0.
- op_i  in  4  alu_op_t opcode.
- a_i  in  DATA_WIDTH  operand A (accumulator).
- b_i  in  DATA_WIDTH  operand B (B/C/temp register).
- busy_o  out  1  high while a multiply iterates.
- done_o  out  1  one-cycle pulse when result_o/flags are valid.
- result_o  out  DATA_WIDTH  registered result (product low half for MUL).
- result_hi_o  out  DATA_WIDTH  product high half; 0 after non-MUL ops.
- flag_zero_o  out  1  registered Z.
- flag_negative_o  out  1  registered N.
- flag_carry_o  out  1  registered C.
- flag_overflow_o  out  1  registered V.

Behaviour:
- Reset: every output is 0. State is IDLE, iteration counter is 0.
- States: IDLE and MUL.
- IDLE, start_i=1, op≠MUL (or ENABLE_MUL=0): result and flags register on the same edge. done_o=1 for the next cycle. State stays IDLE. Latency is 1 cycle, back-to-back starts allowed.
- IDLE, start_i=1, op=MUL: latch operands, clear the accumulator, busy_o=1, go to MUL.
- MUL: one shift-and-add step per clock, DATA_WIDTH steps. On the last step, register the result, pulse done_o, drop busy_o, return to IDLE. Start-to-done latency is DATA_WIDTH+1 cycles.
- start_i while busy_o=1 is ignored; no queueing.
- Flags and results hold between ops.
- Reset asserted mid-multiply aborts at once. All outputs go to 0 and no done_o is issued.
- Ops, with unsigned width-wrapped arithmetic:
  - ADD, ADC: carry-in is the flag C.
  - SUB, SBB: C=1 means borrow.
  - AND, OR, XOR, NOT(A).
  - PASS_B: the load path.
  - INC, DEC on A.
  - SHL, SHR (logical), ROL, ROR through bit, no carry.
  - MUL.
- Z and N: Z=(result==0), N=result msb, for every op except MUL.
- C:
  - ADD/ADC/SUB/SBB: carry-out or borrow.
  - AND/OR/XOR/NOT: forced to 0.
  - Shifts/rotates: the bit moved out.
  - PASS_B, INC, DEC: unchanged.
  - MUL: C=(hi≠0).
- V:
  - Add/sub: signed overflow.
  - Logic ops: 0.
  - All other ops: unchanged.
- MUL flags: Z=(full 2·DATA_WIDTH product==0), N=hi msb, V=0.
- INC of all-ones wraps to 0 with Z=1, C unchanged. DEC of 0 wraps to all-ones.

Decomposition:
- arch_defs_pkg gets:
  - the alu_op_t enum, values: ADD 0, ADC 1, SUB 2, SBB 3, AND 4, OR 5, XOR 6, NOT 7, PASS_B 8, INC 9, DEC A, SHL B, SHR C, ROL D, ROR E, MUL F;
  - the flag-index constants;
  - the alu_state_t enum.
- Natural sub-module: alu_seq_mul, the iterative shift-add multiplier. It has its own start/busy/done and is instantiated only when ENABLE_MUL=1.
- Combinational op decode stays in the top module.

Test Plan:
All scenarios use DATA_WIDTH=8 unless stated.
- Reset mid-flight: assert reset during MUL cycle 3 → all outputs 0 immediately, no done_o; next ADD 01+01 → 02, done 1 cycle later.
- Logic op clears carry: ADD E1+FE → result DF, C=1, N=1, Z=0, V=0. Then AND DF&FE → DE, C=0, N=1. Then AND DE&00 → 00, Z=1, N=0, C=0.
- Signed overflow, carry reset: ADD 7F+01 → 80, V=1, N=1, C=0. Then SUB 00−01 → FF, C=1 (borrow), V=0.
- INC/ADC/ROR: INC FF → 00, Z=1, prior C preserved. ADC 10+10 with C=1 → 21. ROR 01 → 80, C=1.
- Multiply: MUL 0F×11 → busy_o high for 8 cycles, done at cycle 9, result 0xFF, hi 0x00, C=0. MUL FF×FF → lo 01, hi FE, C=1, N=1.
- Busy and wider build: start_i pulses while busy → ignored, operands unchanged. With DATA_WIDTH=16: ADD FFFF+0001 → 0000, Z=1, C=1.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Shared SAP datapath definitions: ALU opcodes, flag bit positions
// and the execution-unit state encoding.
package arch_defs_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_ADC    = 4'h1,
        OP_SUB    = 4'h2,
        OP_SBB    = 4'h3,
        OP_AND    = 4'h4,
        OP_OR     = 4'h5,
        OP_XOR    = 4'h6,
        OP_NOT    = 4'h7,
        OP_PASS_B = 4'h8,
        OP_INC    = 4'h9,
        OP_DEC    = 4'hA,
        OP_SHL    = 4'hB,
        OP_SHR    = 4'hC,
        OP_ROL    = 4'hD,
        OP_ROR    = 4'hE,
        OP_MUL    = 4'hF
    } alu_op_t;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_C    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-and-add multiplier, one partial product per clock.
// done marks the cycle whose closing edge performs the final step.
module alu_seq_mul #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    logic            busy;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  mcand;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    mplier;

    // product already includes the step taken on the coming edge
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (count == CW'(W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            mcand  <= {{W{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with Z/N/C/V flag register and optional iterative
// multiply behind a start/done handshake.
module alu_seq_unit
    import arch_defs_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ENABLE_MUL = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  alu_op_t               op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [DATA_WIDTH-1:0] result_hi_o,
    output logic                  flag_zero_o,
    output logic                  flag_negative_o,
    output logic                  flag_carry_o,
    output logic                  flag_overflow_o
);

    localparam int W   = DATA_WIDTH;
    localparam int MSB = DATA_WIDTH - 1;

    alu_state_t           state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [W-1:0]         res_q;
    logic [W-1:0]         hi_q;
    logic [NUM_FLAGS-1:0] flags_q;

    logic [W:0]           ext;
    logic [W-1:0]         res_d;
    logic                 c_d;
    logic                 v_d;
    logic                 cin;
    logic                 is_mul;
    logic                 mul_done;
    logic [2*W-1:0]       mul_product;

    assign is_mul = (op_i == OP_MUL) && (ENABLE_MUL != 0);
    assign cin    = flags_q[FLAG_C];

    generate
        if (ENABLE_MUL != 0) begin : g_mul
            logic mul_start;
            assign mul_start = start_i && (state_q == ST_IDLE) && is_mul;

            alu_seq_mul #(
                .DATA_WIDTH (W)
            ) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (mul_start),
                .a       (a_i),
                .b       (b_i),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_comb begin
        ext   = '0;
        res_d = '0;
        c_d   = flags_q[FLAG_C];
        v_d   = flags_q[FLAG_V];
        unique case (op_i)
            OP_ADD, OP_ADC: begin
                ext   = {1'b0, a_i} + {1'b0, b_i}
                      + {{W{1'b0}}, (op_i == OP_ADC) & cin};
                res_d = ext[MSB:0];
                c_d   = ext[W];
                v_d   = (a_i[MSB] == b_i[MSB]) && (res_d[MSB] != a_i[MSB]);
            end
            OP_SUB, OP_SBB: begin
                ext   = {1'b0, a_i} - {1'b0, b_i}
                      - {{W{1'b0}}, (op_i == OP_SBB) & cin};
                res_d = ext[MSB:0];
                c_d   = ext[W];
                v_d   = (a_i[MSB] != b_i[MSB]) && (res_d[MSB] != a_i[MSB]);
            end
            OP_AND: begin
                res_d = a_i & b_i;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            OP_OR: begin
                res_d = a_i | b_i;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            OP_XOR: begin
                res_d = a_i ^ b_i;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            OP_NOT: begin
                res_d = ~a_i;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            OP_PASS_B, OP_MUL: res_d = b_i;
            OP_INC:            res_d = a_i + W'(1);
            OP_DEC:            res_d = a_i - W'(1);
            OP_SHL: begin
                res_d = {a_i[MSB-1:0], 1'b0};
                c_d   = a_i[MSB];
            end
            OP_SHR: begin
                res_d = {1'b0, a_i[MSB:1]};
                c_d   = a_i[0];
            end
            OP_ROL: begin
                res_d = {a_i[MSB-1:0], a_i[MSB]};
                c_d   = a_i[MSB];
            end
            OP_ROR: begin
                res_d = {a_i[0], a_i[MSB:1]};
                c_d   = a_i[0];
            end
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i && is_mul) begin
                        state_q <= ST_MUL;
                        busy_q  <= 1'b1;
                    end else if (start_i) begin
                        res_q           <= res_d;
                        hi_q            <= '0;
                        done_q          <= 1'b1;
                        flags_q[FLAG_Z] <= (res_d == '0);
                        flags_q[FLAG_N] <= res_d[MSB];
                        flags_q[FLAG_C] <= c_d;
                        flags_q[FLAG_V] <= v_d;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q         <= ST_IDLE;
                        busy_q          <= 1'b0;
                        done_q          <= 1'b1;
                        res_q           <= mul_product[MSB:0];
                        hi_q            <= mul_product[2*W-1:W];
                        flags_q[FLAG_Z] <= (mul_product == '0);
                        flags_q[FLAG_N] <= mul_product[2*W-1];
                        flags_q[FLAG_C] <= |mul_product[2*W-1:W];
                        flags_q[FLAG_V] <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign result_o        = res_q;
    assign result_hi_o     = hi_q;
    assign flag_zero_o     = flags_q[FLAG_Z];
    assign flag_negative_o = flags_q[FLAG_N];
    assign flag_carry_o    = flags_q[FLAG_C];
    assign flag_overflow_o = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit (8-bit with multiplier, plus
// a 16-bit instance for the wide carry case).
module tb_alu_seq_unit;
    import arch_defs_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    alu_op_t     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  res;
    logic [7:0]  hi;
    logic        fz, fn, fc, fv;
    logic [3:0]  flags;

    logic        start_w;
    alu_op_t     op_w;
    logic [15:0] a_w;
    logic [15:0] b_w;
    logic        busy_w;
    logic        done_w;
    logic [15:0] res_w;
    logic [15:0] hi_w;
    logic        fz_w, fn_w, fc_w, fv_w;

    int n_checks;
    int n_fail;

    assign flags = {fz, fn, fc, fv};

    alu_seq_unit #(
        .DATA_WIDTH (8),
        .ENABLE_MUL (1)
    ) dut (
        .clk             (clk),
        .reset           (rst),
        .start_i         (start),
        .op_i            (op),
        .a_i             (a),
        .b_i             (b),
        .busy_o          (busy),
        .done_o          (done),
        .result_o        (res),
        .result_hi_o     (hi),
        .flag_zero_o     (fz),
        .flag_negative_o (fn),
        .flag_carry_o    (fc),
        .flag_overflow_o (fv)
    );

    alu_seq_unit #(
        .DATA_WIDTH (16),
        .ENABLE_MUL (1)
    ) dut_w (
        .clk             (clk),
        .reset           (rst),
        .start_i         (start_w),
        .op_i            (op_w),
        .a_i             (a_w),
        .b_i             (b_w),
        .busy_o          (busy_w),
        .done_o          (done_w),
        .result_o        (res_w),
        .result_hi_o     (hi_w),
        .flag_zero_o     (fz_w),
        .flag_negative_o (fn_w),
        .flag_carry_o    (fc_w),
        .flag_overflow_o (fv_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input alu_op_t o, input logic [7:0] x,
                         input logic [7:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // flags are compared as {Z,N,C,V}
    task automatic op_chk(input string tag, input alu_op_t o,
                          input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] er, input logic [3:0] ef);
        do_op(o, x, y);
        check({tag, "_done"}, done, 1);
        check({tag, "_res"}, res, er);
        check({tag, "_flg"}, flags, ef);
    endtask

    task automatic run_mul(input logic [7:0] x, input logic [7:0] y,
                           input bit inject, output int cyc,
                           output int busy_n);
        do_op(OP_MUL, x, y);
        cyc    = 1;
        busy_n = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            if (inject && cyc == 3) begin
                start = 1'b1;
                op    = OP_ADD;
                a     = 8'h00;
                b     = 8'h00;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int bn;
        int pulses;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op       = OP_ADD;
        a        = '0;
        b        = '0;
        start_w  = 1'b0;
        op_w     = OP_ADD;
        a_w      = '0;
        b_w      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res", res, 0);
        check("rst_hi", hi, 0);
        check("rst_flg", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        op_chk("add_e1fe", OP_ADD, 8'hE1, 8'hFE, 8'hDF, 4'b0110);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        op_chk("and_dffe", OP_AND, 8'hDF, 8'hFE, 8'hDE, 4'b0100);
        op_chk("and_zero", OP_AND, 8'hDE, 8'h00, 8'h00, 4'b1000);
        op_chk("add_ovf", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101);
        op_chk("sub_brw", OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b0110);
        op_chk("inc_ff", OP_INC, 8'hFF, 8'h00, 8'h00, 4'b1010);
        op_chk("adc_c1", OP_ADC, 8'h10, 8'h10, 8'h21, 4'b0000);
        op_chk("ror_01", OP_ROR, 8'h01, 8'h00, 8'h80, 4'b0110);
        op_chk("dec_00", OP_DEC, 8'h00, 8'h00, 8'hFF, 4'b0110);
        op_chk("shl_81", OP_SHL, 8'h81, 8'h00, 8'h02, 4'b0010);
        op_chk("xor_aa", OP_XOR, 8'hAA, 8'hFF, 8'h55, 4'b0000);

        run_mul(8'h0F, 8'h11, 1'b1, cyc, bn);
        check("mul1_cyc", cyc, 9);
        check("mul1_busyn", bn, 8);
        check("mul1_busy", busy, 0);
        check("mul1_done", done, 1);
        check("mul1_lo", res, 8'hFF);
        check("mul1_hi", hi, 8'h00);
        check("mul1_flg", flags, 4'b0000);
        @(posedge clk);
        #1;
        check("mul1_noq", done, 0);
        check("mul1_hold", res, 8'hFF);

        run_mul(8'hFF, 8'hFF, 1'b0, cyc, bn);
        check("mul2_cyc", cyc, 9);
        check("mul2_lo", res, 8'h01);
        check("mul2_hi", hi, 8'hFE);
        check("mul2_flg", flags, 4'b0110);

        op_chk("pass_5a", OP_PASS_B, 8'h00, 8'h5A, 8'h5A, 4'b0010);
        check("pass_hi", hi, 8'h00);

        do_op(OP_MUL, 8'h0F, 8'h11);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_res", res, 0);
        check("abort_busy", busy, 0);
        check("abort_flg", flags, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_nodone", pulses, 0);
        op_chk("post_add", OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000);

        @(negedge clk);
        start_w = 1'b1;
        op_w    = OP_ADD;
        a_w     = 16'hFFFF;
        b_w     = 16'h0001;
        @(posedge clk);
        #1;
        start_w = 1'b0;
        check("w16_done", done_w, 1);
        check("w16_res", res_w, 16'h0000);
        check("w16_flg", {fz_w, fn_w, fc_w, fv_w}, 4'b1010);
        check("w16_idle", busy_w, 0);
        check("w16_hi", hi_w, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
